// File: rtl/at5351_top.sv
`default_nettype none
// =============================================================================
// at5351_top : AT5351 board top - SPI slave control/readback, ADC/AVK counters
// Optional AVK channel: define AT5351_AVK_EN.              Rev 1.0
// =============================================================================
module at5351_top (
   input  logic       clk_12mhz,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_cs,
   output logic       spi_miso,
   input  logic       adc_comp,
   input  logic       pos_comparator,
   input  logic       neg_comparator,
   output logic       clk_4mhz,
   output logic       clk_5ms,
   output logic       clk_not_5ms,
   output logic       adc_countn,
   output logic       comp1_cs,
   output logic       comp2_cs,
   output logic       relay_cs,
   output logic       relay_reset,
   output logic [3:0] input_sel,
   output logic [2:0] mu_sel,
   output logic [3:0] avk_sel,
   output logic       fil1_sel,
   output logic       fil2_sel,
   output logic       ref_avk,
   output logic       antibounce,
   output logic [7:0] rd_data_out
);
   localparam logic [5:0]  SYNC_RST     = 6'b001000;
   localparam logic [15:0] DIV_5MS_LAST = 16'd59999;
   localparam logic [23:0] CNT_MAX      = 24'hFFFFFF;
   localparam logic [3:0]  RELAY_PULSE  = 4'd12;
   localparam logic [7:0]  CMD_ROUTE    = 8'h01;
   localparam logic [7:0]  CMD_RBSRC    = 8'h02;
   localparam logic [7:0]  CMD_DEVSEL   = 8'h03;
   localparam logic [7:0]  CMD_LATCH    = 8'h04;
   localparam logic [7:0]  CMD_RD_ADC   = 8'h05;
   localparam logic [7:0]  CMD_RD_AVK   = 8'h06;

   logic [5:0]  sync1_q, sync2_q;
   logic        sck_s, mosi_s, cs_s, adc_s, pos_s, neg_s;
   logic [1:0]  div3_q;
   logic        clk4_q, clk5_q, tick_w;
   logic [15:0] div5_q;
   logic        sck_prev_q, sck_rise_w, sck_fall_w;
   logic [5:0]  bit_cnt_q;
   logic [15:0] shift_q;
   logic        exec_q, miso_q;
   logic [47:0] resp_q, resp_w;
   logic [7:0]  cmd_w, exec_cmd_w, exec_dat_w;
   logic [3:0]  val_w;
   logic [3:0]  input_sel_q, input_sel_d, avk_sel_q, avk_sel_d;
   logic [2:0]  mu_sel_q, mu_sel_d, cs_q, cs_d, rb_src_q, rb_src_d;
   logic        fil1_q, fil1_d, fil2_q, fil2_d, latch_w;
   logic [3:0]  relay_cnt_q, relay_cnt_d;
   logic [23:0] count_p_q, count_m_q, p_lat_q, m_lat_q, avk_lat_w;

   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         sync1_q <= SYNC_RST;
         sync2_q <= SYNC_RST;
      end else begin
         sync1_q <= {spi_clk, spi_mosi, spi_cs, adc_comp, pos_comparator, neg_comparator};
         sync2_q <= sync1_q;
      end
   end
   assign {sck_s, mosi_s, cs_s, adc_s, pos_s, neg_s} = sync2_q;

   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         div3_q <= 2'd0;
         clk4_q <= 1'b0;
         div5_q <= 16'd0;
         clk5_q <= 1'b0;
      end else begin
         div3_q <= (div3_q == 2'd2) ? 2'd0 : div3_q + 2'd1;
         clk4_q <= (div3_q == 2'd2);
         if (div5_q == DIV_5MS_LAST) begin
            div5_q <= 16'd0;
            clk5_q <= ~clk5_q;
         end else begin
            div5_q <= div5_q + 16'd1;
         end
      end
   end
   assign tick_w = clk4_q;

   assign sck_rise_w = sck_s & ~sck_prev_q;
   assign sck_fall_w = ~sck_s & sck_prev_q;
   assign cmd_w      = {shift_q[6:0], mosi_s};
   assign exec_cmd_w = shift_q[15:8];
   assign exec_dat_w = shift_q[7:0];
   assign val_w      = exec_dat_w[3:0];

   // Response is left-aligned and zero-filled so MISO idles low past its end.
   always_comb begin
      resp_w = {rd_data_out, 40'd0};
      if (cmd_w == CMD_RD_ADC)
         resp_w = {p_lat_q, m_lat_q};
      else if (cmd_w == CMD_RD_AVK)
         resp_w = {avk_lat_w, 24'd0};
   end

   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         sck_prev_q <= 1'b0;
         bit_cnt_q  <= 6'd0;
         shift_q    <= 16'd0;
         exec_q     <= 1'b0;
         resp_q     <= 48'd0;
         miso_q     <= 1'b0;
      end else begin
         sck_prev_q <= sck_s;
         exec_q     <= 1'b0;
         if (cs_s) begin
            bit_cnt_q <= 6'd0;
            miso_q    <= 1'b0;
         end else begin
            if (sck_fall_w) begin
               shift_q <= {shift_q[14:0], mosi_s};
               if (bit_cnt_q != 6'd63)
                  bit_cnt_q <= bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd7)
                  resp_q <= resp_w;
               if (bit_cnt_q == 6'd15)
                  exec_q <= 1'b1;
            end
            if (sck_rise_w) begin
               if (bit_cnt_q >= 6'd8) begin
                  miso_q <= resp_q[47];
                  resp_q <= {resp_q[46:0], 1'b0};
               end else begin
                  miso_q <= 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      input_sel_d = input_sel_q;
      mu_sel_d    = mu_sel_q;
      avk_sel_d   = avk_sel_q;
      fil1_d      = fil1_q;
      fil2_d      = fil2_q;
      cs_d        = cs_q;
      rb_src_d    = rb_src_q;
      relay_cnt_d = (relay_cnt_q != 4'd0) ? relay_cnt_q - 4'd1 : 4'd0;
      latch_w     = 1'b0;
      if (exec_q) begin
         case (exec_cmd_w)
            CMD_ROUTE: begin
               case (exec_dat_w[7:4])
                  4'h1: if (val_w >= 4'd1 && val_w <= 4'd4) input_sel_d = 4'b0001 << (val_w - 4'd1);
                        else if (val_w == 4'hF) input_sel_d = 4'b0000;
                  4'h2: if (val_w >= 4'd1 && val_w <= 4'd3) mu_sel_d = 3'b001 << (val_w - 4'd1);
                  4'h3: if (val_w >= 4'd1 && val_w <= 4'd4) avk_sel_d = 4'b0001 << (val_w - 4'd1);
                        else if (val_w == 4'hF) avk_sel_d = 4'b0000;
                  4'h4: if (val_w == 4'h0) fil1_d = 1'b0; else if (val_w == 4'hF) fil1_d = 1'b1;
                  4'h5: if (val_w == 4'h0) fil2_d = 1'b0; else if (val_w == 4'hF) fil2_d = 1'b1;
                  default: ;
               endcase
            end
            CMD_RBSRC: if (exec_dat_w >= 8'd1 && exec_dat_w <= 8'd5) rb_src_d = exec_dat_w[2:0];
            CMD_DEVSEL: begin
               case (exec_dat_w)
                  8'h01:   cs_d = 3'b011;
                  8'h02:   cs_d = 3'b101;
                  8'h03:   cs_d = 3'b110;
                  8'h04:   relay_cnt_d = RELAY_PULSE;
                  8'h0F:   cs_d = 3'b111;
                  default: ;
               endcase
            end
            CMD_LATCH: latch_w = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         input_sel_q <= 4'd0;
         mu_sel_q    <= 3'd0;
         avk_sel_q   <= 4'd0;
         fil1_q      <= 1'b0;
         fil2_q      <= 1'b0;
         cs_q        <= 3'b111;
         rb_src_q    <= 3'd1;
         relay_cnt_q <= 4'd0;
      end else begin
         input_sel_q <= input_sel_d;
         mu_sel_q    <= mu_sel_d;
         avk_sel_q   <= avk_sel_d;
         fil1_q      <= fil1_d;
         fil2_q      <= fil2_d;
         cs_q        <= cs_d;
         rb_src_q    <= rb_src_d;
         relay_cnt_q <= relay_cnt_d;
      end
   end

   // A latch wins over a coincident tick: the pre-tick value is captured.
   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         count_p_q <= 24'd0;
         count_m_q <= 24'd0;
         p_lat_q   <= 24'd0;
         m_lat_q   <= 24'd0;
      end else if (latch_w) begin
         p_lat_q   <= count_p_q;
         m_lat_q   <= count_m_q;
         count_p_q <= 24'd0;
         count_m_q <= 24'd0;
      end else if (tick_w) begin
         if (adc_s) begin
            if (count_p_q != CNT_MAX) count_p_q <= count_p_q + 24'd1;
         end else begin
            if (count_m_q != CNT_MAX) count_m_q <= count_m_q + 24'd1;
         end
      end
   end

`ifdef AT5351_AVK_EN
   logic [3:0]  pos_db_cnt_q, neg_db_cnt_q;
   logic        pos_db_q, neg_db_q, antibounce_q;
   logic [23:0] avk_cnt_q, avk_lat_q;

   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         pos_db_cnt_q <= 4'd0;
         neg_db_cnt_q <= 4'd0;
         pos_db_q     <= 1'b0;
         neg_db_q     <= 1'b0;
         antibounce_q <= 1'b0;
         avk_cnt_q    <= 24'd0;
         avk_lat_q    <= 24'd0;
      end else begin
         if (pos_s == pos_db_q) pos_db_cnt_q <= 4'd0;
         else if (pos_db_cnt_q == 4'hF) begin
            pos_db_q     <= pos_s;
            pos_db_cnt_q <= 4'd0;
         end else pos_db_cnt_q <= pos_db_cnt_q + 4'd1;
         if (neg_s == neg_db_q) neg_db_cnt_q <= 4'd0;
         else if (neg_db_cnt_q == 4'hF) begin
            neg_db_q     <= neg_s;
            neg_db_cnt_q <= 4'd0;
         end else neg_db_cnt_q <= neg_db_cnt_q + 4'd1;
         antibounce_q <= pos_db_q ^ neg_db_q;
         if (latch_w) begin
            avk_lat_q <= avk_cnt_q;
            avk_cnt_q <= 24'd0;
         end else if (tick_w && pos_db_q && avk_cnt_q != CNT_MAX) begin
            avk_cnt_q <= avk_cnt_q + 24'd1;
         end
      end
   end
   assign avk_lat_w  = avk_lat_q;
   assign ref_avk    = |avk_sel_q;
   assign antibounce = antibounce_q;
`else
   assign avk_lat_w  = 24'd0;
   assign ref_avk    = 1'b0;
   assign antibounce = 1'b0;
`endif

   always_comb begin
      rd_data_out = 8'd0;
      case (rb_src_q)
         3'd1:    rd_data_out = {input_sel_q, avk_sel_q};
         3'd2:    rd_data_out = {3'b000, mu_sel_q, fil1_q, fil2_q};
         3'd3:    rd_data_out = {4'b0000, cs_q, relay_reset};
         3'd4:    rd_data_out = count_p_q[7:0];
         3'd5:    rd_data_out = {5'b00000, adc_s, pos_s, neg_s};
         default: ;
      endcase
   end

   assign spi_miso    = miso_q;
   assign clk_4mhz    = clk4_q;
   assign clk_5ms     = clk5_q;
   assign clk_not_5ms = ~clk5_q;
   assign adc_countn  = ~adc_s;
   assign comp1_cs    = cs_q[2];
   assign comp2_cs    = cs_q[1];
   assign relay_cs    = cs_q[0];
   assign relay_reset = (relay_cnt_q != 4'd0);
   assign input_sel   = input_sel_q;
   assign mu_sel      = mu_sel_q;
   assign avk_sel     = avk_sel_q;
   assign fil1_sel    = fil1_q;
   assign fil2_sel    = fil2_q;
endmodule
`default_nettype wire

// File: tb/tb_at5351_top.sv
`default_nettype none
// =============================================================================
// tb_at5351_top : directed table and sequence bench for at5351_top   Rev 1.0
// =============================================================================
module tb_at5351_top;
   localparam int H = 4;
   localparam logic [30:0] RESET_STATE = {3'b111, 5'b00001, 23'd0};

   logic clk_12mhz = 1'b0, rst = 1'b1;
   logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
   logic adc_comp = 1'b0, pos_comparator = 1'b0, neg_comparator = 1'b0;
   logic spi_miso, clk_4mhz, clk_5ms, clk_not_5ms, adc_countn;
   logic comp1_cs, comp2_cs, relay_cs, relay_reset, fil1_sel, fil2_sel, ref_avk, antibounce;
   logic [3:0] input_sel, avk_sel;
   logic [2:0] mu_sel;
   logic [7:0] rd_data_out;

   int checks = 0, errors = 0, cyc = 0, relay_hi = 0, last_fall = 0;
   logic done_5ms = 1'b0;

   typedef struct {
      logic [15:0] frame;
      logic [23:0] exp;
   } vec_t;
   vec_t vecs[23];

   at5351_top dut (
      .clk_12mhz(clk_12mhz), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
      .spi_miso(spi_miso), .adc_comp(adc_comp), .pos_comparator(pos_comparator),
      .neg_comparator(neg_comparator), .clk_4mhz(clk_4mhz), .clk_5ms(clk_5ms),
      .clk_not_5ms(clk_not_5ms), .adc_countn(adc_countn), .comp1_cs(comp1_cs),
      .comp2_cs(comp2_cs), .relay_cs(relay_cs), .relay_reset(relay_reset),
      .input_sel(input_sel), .mu_sel(mu_sel), .avk_sel(avk_sel), .fil1_sel(fil1_sel),
      .fil2_sel(fil2_sel), .ref_avk(ref_avk), .antibounce(antibounce), .rd_data_out(rd_data_out)
   );

   always #5 clk_12mhz = ~clk_12mhz;
   always @(posedge clk_12mhz) cyc <= cyc + 1;
   always @(negedge clk_12mhz) if (relay_reset) relay_hi <= relay_hi + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_near(input string name, input int act, input int exp, input int tol);
      checks++;
      if (act < exp - tol || act > exp + tol) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_12mhz);
   endtask

   task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [63:0] rx);
      rx = '0;
      @(negedge clk_12mhz);
      spi_cs = 1'b0;
      cycles(H);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = (i < 16) ? word[15-i] : 1'b0;
         spi_clk  = 1'b1;
         cycles(H);
         rx = {rx[62:0], spi_miso};
         spi_clk   = 1'b0;
         last_fall = cyc;
         cycles(H);
      end
      spi_cs = 1'b1;
      cycles(8);
   endtask

   function automatic logic [30:0] pack_state();
      return {comp1_cs, comp2_cs, relay_cs, relay_reset, spi_miso, clk_4mhz, clk_5ms, clk_not_5ms,
              input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel, ref_avk, antibounce, rd_data_out};
   endfunction

   function automatic logic [23:0] mk(input logic [3:0] in, input logic [2:0] mu, input logic [3:0] avk,
                                      input logic f1, input logic f2, input logic [2:0] cs,
                                      input logic [7:0] rd);
      return {in, mu, avk, f1, f2, cs, rd};
   endfunction

   initial begin : p_5ms
      int n;
      n = 0;
      @(negedge rst);
      while (n < 70000) begin
         @(posedge clk_12mhz);
         #1;
         n++;
         if (clk_5ms) break;
      end
      check("clk_5ms_toggle_cycles", n, 60000);
      check("clk_not_5ms_inverse", clk_not_5ms, 1'b0);
      done_5ms = 1'b1;
   end

   initial begin : p_main
      logic [63:0] rx;
      logic [7:0]  prev_rd;
      int k, t0, t1, t2;
      logic dropped;

      vecs[0]  = '{16'h0112, mk(4'b0010, 3'b000, 4'b0000, 1'b0, 1'b0, 3'b111, 8'h20)};
      vecs[1]  = '{16'h011F, mk(4'b0000, 3'b000, 4'b0000, 1'b0, 1'b0, 3'b111, 8'h00)};
      vecs[2]  = '{16'h015F, mk(4'b0000, 3'b000, 4'b0000, 1'b0, 1'b1, 3'b111, 8'h00)};
      vecs[3]  = '{16'h0133, mk(4'b0000, 3'b000, 4'b0100, 1'b0, 1'b1, 3'b111, 8'h04)};
      vecs[4]  = '{16'h0114, mk(4'b1000, 3'b000, 4'b0100, 1'b0, 1'b1, 3'b111, 8'h84)};
      vecs[5]  = '{16'h0122, mk(4'b1000, 3'b010, 4'b0100, 1'b0, 1'b1, 3'b111, 8'h84)};
      vecs[6]  = '{16'h0202, mk(4'b1000, 3'b010, 4'b0100, 1'b0, 1'b1, 3'b111, 8'h09)};
      vecs[7]  = '{16'h014F, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b111, 8'h0B)};
      vecs[8]  = '{16'h0129, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b111, 8'h0B)};
      vecs[9]  = '{16'h0115, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b111, 8'h0B)};
      vecs[10] = '{16'h0302, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b101, 8'h0B)};
      vecs[11] = '{16'h0203, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b101, 8'h0A)};
      vecs[12] = '{16'h030F, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b111, 8'h0E)};
      vecs[13] = '{16'h0207, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b111, 8'h0E)};
      vecs[14] = '{16'h0301, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b011, 8'h06)};
      vecs[15] = '{16'h0755, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b011, 8'h06)};
      vecs[16] = '{16'h0303, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b110, 8'h0C)};
      vecs[17] = '{16'h030F, mk(4'b1000, 3'b010, 4'b0100, 1'b1, 1'b1, 3'b111, 8'h0E)};
      vecs[18] = '{16'h013F, mk(4'b1000, 3'b010, 4'b0000, 1'b1, 1'b1, 3'b111, 8'h0E)};
      vecs[19] = '{16'h0201, mk(4'b1000, 3'b010, 4'b0000, 1'b1, 1'b1, 3'b111, 8'h80)};
      vecs[20] = '{16'h0110, mk(4'b1000, 3'b010, 4'b0000, 1'b1, 1'b1, 3'b111, 8'h80)};
      vecs[21] = '{16'h0205, mk(4'b1000, 3'b010, 4'b0000, 1'b1, 1'b1, 3'b111, 8'h00)};
      vecs[22] = '{16'h0201, mk(4'b1000, 3'b010, 4'b0000, 1'b1, 1'b1, 3'b111, 8'h80)};

      cycles(4);
      check("reset_state", pack_state(), RESET_STATE);
      rst = 1'b0;

      k = 0;
      while (!clk_4mhz && k < 10) begin cycles(1); k++; end
      k = 0;
      do begin cycles(1); k++; end while (!clk_4mhz && k < 10);
      check("clk_4mhz_period", k, 3);
      cycles(1);
      check("clk_4mhz_high_one_cycle", clk_4mhz, 1'b0);

      prev_rd = 8'h00;
      for (int i = 0; i < 23; i++) begin
         spi_frame(vecs[i].frame, 16, rx);
         check($sformatf("vec%0d_outputs", i),
               {input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel, comp1_cs, comp2_cs, relay_cs, rd_data_out},
               vecs[i].exp);
         check($sformatf("vec%0d_miso", i), rx[15:0], {8'h00, prev_rd});
         prev_rd = vecs[i].exp[7:0];
      end

      spi_frame(16'h0113, 12, rx);
      check("partial_frame_ignored", input_sel, 4'b1000);
      spi_frame(16'h0113, 16, rx);
      check("frame_after_partial", input_sel, 4'b0100);

      check("relay_idle", relay_hi, 0);
      spi_frame(16'h0304, 16, rx);
      cycles(20);
      check("relay_pulse_width", relay_hi, 12);

      adc_comp = 1'b1;
      cycles(4);
      check("adc_countn_inverted", adc_countn, 1'b0);
      spi_frame(16'h0400, 16, rx);
      t0 = last_fall;
      cycles(9000);
      adc_comp = 1'b0;
      t1 = cyc;
      cycles(6000);
      spi_frame(16'h0400, 16, rx);
      t2 = last_fall;
      spi_frame(16'h0500, 56, rx);
      check("adc_readout_cmd_phase", rx[55:48], 8'h00);
      check_near("count_p", int'(rx[47:24]), (t1 - t0) / 3, 4);
      check_near("count_m", int'(rx[23:0]), (t2 - t1) / 3, 4);

      spi_frame(16'h0131, 16, rx);
`ifdef AT5351_AVK_EN
      check("ref_avk", ref_avk, 1'b1);
      spi_frame(16'h0400, 16, rx);
      pos_comparator = 1'b1;
      t0 = cyc;
      cycles(1500);
      check("antibounce_set", antibounce, 1'b1);
      pos_comparator = 1'b0;
      dropped = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == 10) pos_comparator = 1'b1;
         cycles(1);
         if (!antibounce) dropped = 1'b1;
      end
      check("antibounce_glitch", dropped, 1'b0);
      cycles(1500);
      pos_comparator = 1'b0;
      t1 = cyc;
      cycles(50);
      spi_frame(16'h0400, 16, rx);
      spi_frame(16'h0600, 32, rx);
      check_near("avk_cnt", int'(rx[23:0]), (t1 - t0) / 3, 4);
`else
      check("ref_avk_off", ref_avk, 1'b0);
      pos_comparator = 1'b1;
      cycles(600);
      check("antibounce_off", antibounce, 1'b0);
      spi_frame(16'h0400, 16, rx);
      spi_frame(16'h0600, 32, rx);
      check("avk_cnt_off", rx[31:0], 32'd0);
      pos_comparator = 1'b0;
`endif

      k = 0;
      while (!done_5ms && k < 80000) begin cycles(1); k++; end
      if (!done_5ms) begin
         checks++;
         errors++;
         $display("FAIL clk_5ms_timeout: got no toggle expected toggle within budget");
      end

      @(negedge clk_12mhz);
      spi_cs = 1'b0;
      cycles(H);
      for (int i = 0; i < 5; i++) begin
         spi_mosi = 1'b1;
         spi_clk  = 1'b1;
         cycles(H);
         spi_clk  = 1'b0;
         cycles(H);
      end
      rst = 1'b1;
      cycles(2);
      check("midframe_reset_state", pack_state(), RESET_STATE);
      spi_cs = 1'b1;
      cycles(4);
      rst = 1'b0;
      cycles(4);
      spi_frame(16'h0111, 16, rx);
      check("frame_after_reset", input_sel, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/at5351_top.md
# at5351_top

FPGA top level of the AT5351 measurement board. It runs from the 12 MHz board clock and contains a byte-oriented SPI slave. Over SPI a host controls analog routing selects, peripheral chip-selects and a relay reset, reads back status, and reads latched 24-bit counts from the integrating-ADC comparator and the AVK (capacitance) comparator channel.

## Interface
- No parameters. Fixed divisors: 4 MHz = 12 MHz / 3; 5 ms = 60000 cycles.
- `clk_12mhz` in 1: sole clock.
- `rst` in 1: asynchronous reset, active-high.
- `spi_clk`, `spi_mosi`, `spi_cs` in 1: SPI slave inputs; CPOL=0; `spi_cs` is active-low.
- `spi_miso` out 1: SPI data out, MSB first.
- `adc_comp` in 1: ADC comparator.
- `pos_comparator`, `neg_comparator` in 1: AVK comparators.
- `clk_4mhz` out 1; `clk_5ms` out 1; `clk_not_5ms` out 1.
- `adc_countn` out 1: synchronized, inverted `adc_comp`.
- `comp1_cs`, `comp2_cs`, `relay_cs` out 1: active-low chip-selects.
- `relay_reset` out 1: active-high pulse.
- `input_sel` out 4, `mu_sel` out 3, `avk_sel` out 4: one-hot selects.
- `fil1_sel`, `fil2_sel` out 1: filter enables.
- `ref_avk` out 1; `antibounce` out 1.
- `rd_data_out` out 8: selected readback byte.

## Operation
- All async inputs pass through 2-FF synchronizers. SPI edges are detected on the synchronized `spi_clk` in the `clk_12mhz` domain.
- **SPI framing**
  - `spi_cs` low opens a frame; `spi_cs` high aborts it and clears the bit counter.
  - MOSI is sampled on SCK falling edges, MSB first.
  - Byte 0 is CMD; byte 1 is DATA.
  - A command executes once, 1 cycle after the 16th sampled bit. Partial frames are discarded.
- **MISO**
  - Shifted on SCK rising edges.
  - During bits 0-7, MISO drives 0.
  - From bit 8 onward it drives a response latched when CMD completes:
    - CMD 0x05: 48 bits, `count_p[23:0]` then `count_m[23:0]`.
    - CMD 0x06: 24 bits, `avk_cnt`.
    - Any other CMD: `rd_data_out`.
  - MISO is 0 beyond the response length.
- **CMD 0x01: routing.** The upper nibble of DATA selects the group; the lower nibble is the value.
  - Group 1: values 1-4 set `input_sel` to one-hot bit v-1; value F clears it.
  - Group 2: values 1-3 set `mu_sel` to one-hot bit v-1.
  - Group 3: values 1-4 set `avk_sel` to one-hot bit v-1; value F clears it.
  - Group 4: value 0 or F sets `fil1_sel` to 0 or 1.
  - Group 5: value 0 or F sets `fil2_sel` to 0 or 1.
  - Any other value leaves the output unchanged.
- **CMD 0x02: readback source.** DATA selects the source of `rd_data_out`:
  - 1: {`input_sel`, `avk_sel`}
  - 2: {3'b0, `mu_sel`, `fil1_sel`, `fil2_sel`}
  - 3: {4'b0, `comp1_cs`, `comp2_cs`, `relay_cs`, `relay_reset`}
  - 4: `count_p[7:0]`
  - 5: {5'b0, `adc_comp`, `pos`, `neg`}, all synchronized values.
  - Other values: ignored.
- **CMD 0x03: device select.**
  - DATA 1/2/3 drives `comp1_cs`, `comp2_cs` or `relay_cs` low respectively, with the others high.
  - DATA 4 issues a 12-cycle `relay_reset` pulse.
  - DATA 0x0F drives all CS high.
- **CMD 0x04: latch.** Copies the live ADC and AVK counters into the latches, then clears the live counters.
- **CMD 0x05 / 0x06:** readout only; no state change.
- Unknown CMD values are ignored.
- **ADC counters**
  - Both are 24-bit and saturate at 0xFFFFFF.
  - `count_p` increments on each 4 MHz tick while synchronized `adc_comp` is 1.
  - `count_m` increments on each 4 MHz tick while it is 0.
- **Clocks**
  - `clk_4mhz` is 1 for 1 cycle in 3 and also serves as the tick enable.
  - `clk_5ms` toggles every 60000 cycles.
  - `clk_not_5ms` is the inverse of `clk_5ms`.

## Timing
- Reset values:
  - All CS outputs 1.
  - `relay_reset`, `spi_miso`, `clk_4mhz`, `clk_5ms` 0; `clk_not_5ms` 1.
  - All selects, filters and `rd_data_out` 0; readback source 1.
  - All counters and latches 0.
  - `ref_avk`, `antibounce` 0.
- Latency: command effect 1 cycle after the 16th bit, at most 4 cycles after the SCK edge.
- Maximum SCK frequency is 2 MHz (SCK high/low ≥ 3 cycles).
- `rst` asserted mid-frame aborts the frame and restores all reset values.
- A latch (CMD 0x04) coinciding with a tick: the pre-tick value is latched and the counter restarts at 0.

## Configuration
- `AT5351_AVK_EN` defined:
  - `pos`/`neg` debounced with 16-cycle stability filters.
  - `antibounce` is 1 while `pos` ≠ `neg` and both are stable.
  - `ref_avk` = |`avk_sel`.
  - `avk_cnt` (24-bit, saturating) counts 4 MHz ticks while debounced `pos` is 1, and is latched/cleared by CMD 0x04.
- Undefined: `ref_avk`, `antibounce` and `avk_cnt` are constant 0; CMD 0x06 returns zeros.

## Test plan
- Reset: assert `rst` -> all CS=1, selects=0, `clk_not_5ms`=1; release -> `clk_4mhz` period 3 cycles, `clk_5ms` toggles at 60000 cycles.
- Frames 0x01/0x12, 0x01/0x1F, 0x01/0x5F -> `input_sel`=4'b0010, then 0; `fil2_sel`=1.
- Frame 0x03/0x02 -> `comp2_cs`=0, others 1; 0x03/0x04 -> `relay_reset` high 12 cycles; 0x03/0x0F -> all CS 1.
- `adc_comp` 1 for 6 ms, 0 for 4 ms, then 0x04 and 0x05 frames -> MISO returns `count_p`≈24000, `count_m`≈16000, ±4.
- `spi_cs` raised after 12 bits of 0x01/0x13 -> no change; next full frame executes normally.
- With `AT5351_AVK_EN`: `pos` high 12 ms, then 0x04 and 0x06 -> `avk_cnt`≈48000; a 10-cycle glitch on `pos` -> `antibounce` unchanged.
